// File: rtl/fir_seq_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_pkg                                                          |
// | Shared states, pattern-select encodings and stored excitations   |
// | for the FIR test-sequencing controller.                          |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_DRIVE = 3'd2,
        ST_TAIL  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] SEL_IMP_POS = 3'd0;
    localparam logic [2:0] SEL_IMP_NEG = 3'd1;
    localparam logic [2:0] SEL_POS100  = 3'd2;
    localparam logic [2:0] SEL_NEG100  = 3'd3;
    localparam logic [2:0] SEL_WC_MAX  = 3'd4;
    localparam logic [2:0] SEL_WC_MIN  = 3'd5;
    localparam logic [2:0] SEL_STEP    = 3'd6;
    localparam logic [2:0] SEL_ILLEGAL = 3'd7;

    localparam int c_len_single = 1;
    localparam int c_len_wc     = 7;

    localparam logic signed [7:0] c_amp_100 = 8'sd100;

    // Element k sits at bits [8k+7:8k]; the top byte pads the vector so a
    // 3-bit index never selects past the end.
    localparam logic [63:0] c_wc_max_pat =
        {8'h00, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80};
    localparam logic [63:0] c_wc_min_pat =
        {8'h00, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F};

endpackage
`default_nettype wire

// File: rtl/fir_seq_ctrl_pattern_rom.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_pattern_rom                                                  |
// | Combinational map from (pattern select, index) to (sample, last).|
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fir_pattern_rom
    import fir_pkg::*;
#(
    parameter int DW   = 8,
    parameter int TAPS = 7,
    parameter int KW   = 8
) (
    input  logic [2:0]    i_sel,
    input  logic [KW-1:0] i_k,
    output logic [DW-1:0] o_sample,
    output logic          o_last
);

    logic signed [7:0] w_raw;
    logic [KW-1:0]     w_len;

    always_comb begin
        w_raw = '0;
        w_len = KW'(c_len_single);
        case (i_sel)
            SEL_IMP_POS: w_raw = 8'sd1;
            SEL_IMP_NEG: w_raw = -8'sd1;
            SEL_POS100:  w_raw = c_amp_100;
            SEL_NEG100:  w_raw = -c_amp_100;
            SEL_WC_MAX: begin
                w_len = KW'(c_len_wc);
                w_raw = c_wc_max_pat[{i_k[2:0], 3'b000} +: 8];
            end
            SEL_WC_MIN: begin
                w_len = KW'(c_len_wc);
                w_raw = c_wc_min_pat[{i_k[2:0], 3'b000} +: 8];
            end
            SEL_STEP: begin
                w_len = KW'(TAPS);
                w_raw = c_amp_100;
            end
            default: ;
        endcase
        // Reading past the end of a pattern yields silence.
        if (i_k >= w_len) begin
            w_raw = '0;
        end
    end

    assign o_sample = DW'(w_raw);
    assign o_last   = (i_k >= w_len - 1'b1);

endmodule
`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_seq_ctrl                                                     |
// | Flushes the FIR, plays a stored pattern, waits out the tail and  |
// | reports the signed min/max of the filter output.                 |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int DW    = 8,
    parameter int YW    = 10,
    parameter int TAPS  = 7,
    parameter int LAT   = 1,
    parameter int FLUSH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    sel,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          fir_rst,
    output logic [DW-1:0] x_out,
    input  logic [YW-1:0] y_in,
    output logic [YW-1:0] y_max,
    output logic [YW-1:0] y_min,
    output logic          res_valid
);

    localparam int CW = 8;
    localparam logic [CW-1:0] c_flush_last = CW'(FLUSH - 1);
    localparam logic [CW-1:0] c_tail_last  = CW'(TAPS + LAT - 1);
    localparam logic [CW-1:0] c_lat        = CW'(LAT);

    state_t        r_state, w_state;
    logic [2:0]    r_sel, w_sel;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [CW-1:0] r_idx, w_idx;
    logic [CW-1:0] r_lat_cnt, w_lat_cnt;
    logic          r_x_last, w_x_last;
    logic          r_first, w_first;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic          r_err, w_err;
    logic          r_fir_rst, w_fir_rst;
    logic [DW-1:0] r_x, w_x;
    logic [YW-1:0] r_y_max, w_y_max;
    logic [YW-1:0] r_y_min, w_y_min;
    logic          r_res_valid, w_res_valid;
    logic          w_in_run, w_cap;
    logic [DW-1:0] w_rom_sample;
    logic          w_rom_last;

    // r_idx always points at the next sample to load into x_out.
    fir_pattern_rom #(
        .DW   (DW),
        .TAPS (TAPS),
        .KW   (CW)
    ) u_rom (
        .i_sel    (r_sel),
        .i_k      (r_idx),
        .o_sample (w_rom_sample),
        .o_last   (w_rom_last)
    );

    always_comb begin
        w_state     = r_state;
        w_sel       = r_sel;
        w_cnt       = r_cnt;
        w_idx       = r_idx;
        w_lat_cnt   = r_lat_cnt;
        w_x_last    = r_x_last;
        w_first     = r_first;
        w_err       = r_err;
        w_res_valid = r_res_valid;
        w_y_max     = r_y_max;
        w_y_min     = r_y_min;
        w_x         = '0;
        w_fir_rst   = 1'b0;

        // Skip the first LAT run cycles so only outputs caused by the
        // pattern and its tail are captured.
        w_in_run = (r_state == ST_DRIVE) || (r_state == ST_TAIL);
        w_cap    = w_in_run && (r_lat_cnt == c_lat);
        if (w_in_run && (r_lat_cnt != c_lat)) begin
            w_lat_cnt = r_lat_cnt + 1'b1;
        end
        if (w_cap) begin
            if (r_first) begin
                w_y_max = y_in;
                w_y_min = y_in;
                w_first = 1'b0;
            end else begin
                if ($signed(y_in) > $signed(r_y_max)) w_y_max = y_in;
                if ($signed(y_in) < $signed(r_y_min)) w_y_min = y_in;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (abort) begin
                    w_res_valid = 1'b0;
                end else if (start) begin
                    w_res_valid = 1'b0;
                    if (sel == SEL_ILLEGAL) begin
                        w_state = ST_DONE;
                        w_err   = 1'b1;
                    end else begin
                        w_state   = ST_FLUSH;
                        w_err     = 1'b0;
                        w_sel     = sel;
                        w_cnt     = '0;
                        w_idx     = '0;
                        w_lat_cnt = '0;
                        w_first   = 1'b1;
                        w_fir_rst = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (r_cnt == c_flush_last) begin
                    w_state  = ST_DRIVE;
                    w_x      = w_rom_sample;
                    w_x_last = w_rom_last;
                    w_idx    = r_idx + 1'b1;
                end else begin
                    w_cnt     = r_cnt + 1'b1;
                    w_fir_rst = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (r_x_last) begin
                    w_state = ST_TAIL;
                    w_cnt   = '0;
                end else begin
                    w_x      = w_rom_sample;
                    w_x_last = w_rom_last;
                    w_idx    = r_idx + 1'b1;
                end
            end
            ST_TAIL: begin
                if (r_cnt == c_tail_last) begin
                    w_state     = ST_DONE;
                    w_res_valid = !r_err;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_DONE: w_state = ST_IDLE;
            default: w_state = ST_IDLE;
        endcase

        // Abort pulses the filter reset once so the next run starts clean.
        if (abort && (r_state == ST_FLUSH || w_in_run)) begin
            w_state     = ST_IDLE;
            w_fir_rst   = 1'b1;
            w_x         = '0;
            w_res_valid = 1'b0;
        end

        w_busy = (w_state == ST_FLUSH) || (w_state == ST_DRIVE) ||
                 (w_state == ST_TAIL);
        w_done = (w_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_lat_cnt   <= '0;
            r_x_last    <= 1'b0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_fir_rst   <= 1'b1;
            r_x         <= '0;
            r_y_max     <= '0;
            r_y_min     <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_sel       <= w_sel;
            r_cnt       <= w_cnt;
            r_idx       <= w_idx;
            r_lat_cnt   <= w_lat_cnt;
            r_x_last    <= w_x_last;
            r_first     <= w_first;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
            r_fir_rst   <= w_fir_rst;
            r_x         <= w_x;
            r_y_max     <= w_y_max;
            r_y_min     <= w_y_min;
            r_res_valid <= w_res_valid;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign fir_rst   = r_fir_rst;
    assign x_out     = r_x;
    assign y_max     = r_y_max;
    assign y_min     = r_y_min;
    assign res_valid = r_res_valid;

endmodule
`default_nettype wire
